// File: rtl/seg7_scan_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decode
// Brief    : Receive side of a 4-digit multiplexed 7-segment display.
//            Synchronises segment lines and active-low digit enables, waits
//            for each digit to settle, decodes it back to BCD and publishes
//            a complete 16-bit frame with a one-cycle strobe.
// Options  : SEG7_DP_CAPTURE_EN adds the dp[3:0] output (decimal points).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decode #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  dig_n,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  err,
    output logic [3:0]  blank,
`ifdef SEG7_DP_CAPTURE_EN
    output logic [3:0]  dp,
`endif
    output logic        stale
);

    localparam int         CNT_W       = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] c_STABLE  = CNT_W'(STABLE_CYC);
    localparam logic [15:0] c_TIMEOUT  = 16'(TIMEOUT_CYC);
    localparam logic [7:0]  c_DP_MASK  = 8'hFB;

    localparam logic [1:0] c_WAIT_SEL = 2'd0;
    localparam logic [1:0] c_SETTLE   = 2'd1;
    localparam logic [1:0] c_HOLD     = 2'd2;

    logic [7:0]       r_seg_sync [SYNC_STAGES];
    logic [3:0]       r_dig_sync [SYNC_STAGES];
    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [3:0]       r_dig_smp;
    logic [7:0]       r_seg_smp;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_sh_value;
    logic [3:0]       r_sh_err;
    logic [3:0]       r_sh_blank;
    logic [3:0]       r_mask;
    logic [3:0]       w_mask_nx;
    logic [15:0]      r_idle_cnt;

    logic [7:0]       w_seg_now;
    logic [3:0]       w_dig_now;
    logic             w_sel_valid;
    logic             w_sel_chg;
    logic             w_seg_chg;
    logic             w_load;
    logic             w_seg_reload;
    logic             w_cnt_inc;
    logic             w_accept;
    logic             w_frame;
    logic [1:0]       w_acc_idx;
    logic [3:0]       w_dec_nib;
    logic             w_dec_err;
    logic             w_dec_blank;

`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]       r_sh_dp;
`endif

    // Input synchronisers for segment lines and digit enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_seg_sync[i] <= '0;
                r_dig_sync[i] <= '0;
            end
        end else begin
            r_seg_sync[0] <= seg_in;
            r_dig_sync[0] <= dig_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_seg_sync[i] <= r_seg_sync[i-1];
                r_dig_sync[i] <= r_dig_sync[i-1];
            end
        end
    end

    // The DP segment never takes part in decode or stability comparison.
    assign w_seg_now   = r_seg_sync[SYNC_STAGES-1] & c_DP_MASK;
    assign w_dig_now   = r_dig_sync[SYNC_STAGES-1];
    assign w_sel_valid = $onehot(~w_dig_now);
    assign w_sel_chg   = (w_dig_now != r_dig_smp);
    assign w_seg_chg   = (w_seg_now != r_seg_smp);
    assign w_frame     = (r_mask == 4'hF);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_WAIT_SEL;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state. On the acceptance cycle the current sample is already
    // judged by the HOLD rule, so a digit change there starts settling at once.
    always_comb begin
        w_state_nx   = r_state;
        w_load       = 1'b0;
        w_seg_reload = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            c_WAIT_SEL: begin
                if (w_sel_valid) begin
                    w_state_nx = c_SETTLE;
                    w_load     = 1'b1;
                end
            end
            c_SETTLE, c_HOLD: begin
                if (w_sel_chg) begin
                    if (w_sel_valid) begin
                        w_state_nx = c_SETTLE;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nx = c_WAIT_SEL;
                    end
                end else if (w_accept || (r_state == c_HOLD)) begin
                    w_state_nx = c_HOLD;
                end else if (w_seg_chg) begin
                    w_seg_reload = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nx = c_WAIT_SEL;
            end
        endcase
    end

    // FSM outputs: digit acceptance once the pattern has been stable long enough.
    always_comb begin
        w_accept = (r_state == c_SETTLE) && (r_cnt == c_STABLE);
    end

    // Sample registers and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_smp <= 4'hF;
            r_seg_smp <= '0;
            r_cnt     <= '0;
        end else if (w_load) begin
            r_dig_smp <= w_dig_now;
            r_seg_smp <= w_seg_now;
            r_cnt     <= CNT_W'(1);
        end else if (w_seg_reload) begin
            r_seg_smp <= w_seg_now;
            r_cnt     <= CNT_W'(1);
        end else if (w_cnt_inc) begin
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Digit position of the captured select.
    always_comb begin
        case (r_dig_smp)
            4'b1110: w_acc_idx = 2'd0;
            4'b1101: w_acc_idx = 2'd1;
            4'b1011: w_acc_idx = 2'd2;
            4'b0111: w_acc_idx = 2'd3;
            default: w_acc_idx = 2'd0;
        endcase
    end

    // Segment pattern to BCD decode of the captured sample.
    always_comb begin
        w_dec_nib   = 4'hF;
        w_dec_err   = 1'b0;
        w_dec_blank = 1'b0;
        case (r_seg_smp)
            8'hEB: w_dec_nib = 4'd0;
            8'h28: w_dec_nib = 4'd1;
            8'hB3: w_dec_nib = 4'd2;
            8'hBA: w_dec_nib = 4'd3;
            8'h78: w_dec_nib = 4'd4;
            8'hDA: w_dec_nib = 4'd5;
            8'hDB: w_dec_nib = 4'd6;
            8'hA8: w_dec_nib = 4'd7;
            8'hFB: w_dec_nib = 4'd8;
            8'hFA: w_dec_nib = 4'd9;
            8'h00: begin
                w_dec_nib   = 4'd0;
                w_dec_blank = 1'b1;
            end
            default: w_dec_err = 1'b1;
        endcase
    end

    // Frame mask update; a capture coinciding with the frame keeps its bit.
    always_comb begin
        w_mask_nx = w_frame ? 4'h0 : r_mask;
        if (w_accept) begin
            w_mask_nx[w_acc_idx] = 1'b1;
        end
    end

    // Shadow registers and frame mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_value <= '0;
            r_sh_err   <= '0;
            r_sh_blank <= '0;
            r_mask     <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            r_sh_dp    <= '0;
`endif
        end else begin
            r_mask <= w_mask_nx;
            if (w_accept) begin
                r_sh_value[{w_acc_idx, 2'b00} +: 4] <= w_dec_nib;
                r_sh_err[w_acc_idx]                 <= w_dec_err;
                r_sh_blank[w_acc_idx]               <= w_dec_blank;
`ifdef SEG7_DP_CAPTURE_EN
                r_sh_dp[w_acc_idx]                  <= r_seg_sync[SYNC_STAGES-1][2];
`endif
            end
        end
    end

    // Published frame and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            err         <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
            dp          <= '0;
`endif
        end else begin
            frame_valid <= w_frame;
            if (w_frame) begin
                value <= r_sh_value;
                err   <= r_sh_err;
                blank <= r_sh_blank;
`ifdef SEG7_DP_CAPTURE_EN
                dp    <= r_sh_dp;
`endif
            end
        end
    end

    // Idle timer and stale flag; a completed frame clears stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            stale      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != c_TIMEOUT) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
            if (w_frame) begin
                stale <= 1'b0;
            end else if (r_idle_cnt == c_TIMEOUT) begin
                stale <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
